pmod_ad1_ctrl: RTL and testbench
================================

// Module: pmod_ad1_ctrl
// PURPOSE
//  SPI read controller for the dual AD7476A on the PmodAD1; sits directly upstream of the Pmod pin remap.
//  Drives ad1_cs/ad1_sclk and shifts in two channels (ad1_sdin0/1) simultaneously.
//  Presents each conversion pair as one AXI4-Stream beat to the fabric (DMA/FIFO/processor).
// PARAMETERS
//  CLK_DIV    2  aclk cycles per SCLK half-period; legal range >=1.
//  QUIET_CYC  4  aclk cycles CS held high after a frame (tQUIET); legal range >=1.
// PORTS
//  aclk           in   1   single clock; all logic on rising edge
//  aresetn        in   1   asynchronous, active-low reset
//  en             in   1   level; high = back-to-back conversions
//  busy           out  1   high from CS fall through end of QUIET
//  ad1_cs         out  1   chip select to remap, active low
//  ad1_sclk       out  1   serial clock to remap, idles high
//  ad1_sdin0      in   1   channel 0 data from remap
//  ad1_sdin1      in   1   channel 1 data from remap
//  m_axis_tdata   out  32  {4'h0, ch1[11:0], 4'h0, ch0[11:0]}
//  m_axis_tvalid  out  1   sample valid
//  m_axis_tready  in   1   downstream accept
// BEHAVIOUR
//  Reset (async assert, sync release): ad1_cs=1, ad1_sclk=1, tvalid=0, tdata=0, busy=0, state=IDLE.
//  Reset mid-frame: CS/SCLK return high immediately; the partial sample is discarded and never emitted.
//  FSM:
//   - IDLE: en=1 -> START on the next edge.
//   - START: cs=0 for CLK_DIV cycles (tCS setup).
//   - SHIFT: 16 bit periods; each is sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
//   - On the aclk edge that raises sclk, shift sdin0/sdin1 into 16b regs, MSB first.
//   - After the 16th high phase: cs=1, go to QUIET.
//   - QUIET: QUIET_CYC cycles with cs=1, sclk=1, then IDLE.
//  Frame length: CS low for CLK_DIV*33 cycles.
//  Period with en held high: 1 + 33*CLK_DIV + QUIET_CYC cycles between CS falls.
//  Frame bits [15:12] are the ADC leading zeros and are ignored; bits [11:0] are the sample.
//  Output register:
//   - Loaded on the edge CS rises, so tvalid is high in the first QUIET cycle.
//   - tdata is stable while tvalid && !tready.
//   - tvalid clears on the edge after tvalid && tready.
//  Output still pending when a new frame completes: the new sample is dropped; the old one is held (AXIS rule).
//  Simultaneous accept and frame completion: the new sample loads and tvalid stays 1.
//  en falling mid-frame: the current frame and QUIET complete, then the FSM stays in IDLE.
//  en is sampled only in IDLE.
//  Counters are sized $clog2 of their max value; no wrap within a frame.
// CONFIGURATION
//  Macro PMOD_AD1_OVERRUN_EN adds two ports:
//   - overrun      out  1  sticky; set when a sample is dropped.
//   - overrun_clr  in   1  synchronous clear; a set in the same cycle wins.
//   - overrun resets to 0.
//  Without the macro: these ports are absent and a dropped sample leaves no trace.
// STRUCTURE
//  pmod_ad1_pkg holds:
//   - state enum {IDLE, START, SHIFT, QUIET}
//   - FRAME_BITS=16, LEAD_ZEROS=4, DATA_BITS=12, TDATA_W=32
//  Sub-module pmod_ad1_sclk_gen:
//   - half-period counter emitting a rise_stb/fall_stb pair
//   - enabled only in START/SHIFT; the FSM counts bits off rise_stb
// TESTING (CLK_DIV=2, QUIET_CYC=4; ADC model drives bits after SCLK fall)
//  1 Reset: hold aresetn=0 -> cs=1, sclk=1, tvalid=0, tdata=0, busy=0.
//  2 Single frame: ch0=0x0ABC, ch1=0x0123, en pulse in IDLE, tready=1.
//    -> cs low 66 cycles, 16 sclk rises, tdata=0x01230ABC, tvalid 1 cycle.
//  3 Continuous: en=1, tready=1 -> CS falls every 71 cycles; 10 frames give 10 beats, values in order.
//  4 Backpressure: tready=0 for 3 frames -> tdata holds the first sample; frames 2-3 dropped.
//    With PMOD_AD1_OVERRUN_EN: overrun=1 until overrun_clr.
//  5 Leading zeros: ADC drives 1s in bits [15:12], data 0xFFF -> tdata=0x0FFF0FFF.
//  6 Reset mid-SHIFT after 7 sclk rises -> cs/sclk high at once, no beat; next frame is correct.

Source files
------------

// File: rtl/pmod_ad1_pkg.sv
// pmod_ad1_pkg: shared types and constants for the PmodAD1 SPI read controller.
//   state_t  - controller FSM states
//   cnt_w()  - width of a counter whose largest value is maxv (at least 1 bit)
package pmod_ad1_pkg;

    typedef enum logic [1:0] {IDLE, START, SHIFT, QUIET} state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int DATA_BITS  = 12;
    localparam int TDATA_W    = 32;

    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/pmod_ad1_sclk_gen.sv
// pmod_ad1_sclk_gen: SCLK half-period generator.
//   clk_i, rst_ni   clock, active-low async reset
//   en_i            run; when low the phase restarts with sclk high
//   sclk_o          raw serial clock level (idles high)
//   rise_stb_o      high in the cycle whose closing edge raises sclk
//   fall_stb_o      high in the cycle whose closing edge lowers sclk
module pmod_ad1_sclk_gen
    import pmod_ad1_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = cnt_w(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        wrap   = en_i && (cnt_q == CNT_MAX);
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b1;
        end else if (wrap) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = wrap && !sclk_q;
    assign fall_stb_o = wrap && sclk_q;

endmodule

// File: rtl/pmod_ad1_ctrl.sv
// pmod_ad1_ctrl: SPI read controller for the dual AD7476A on the PmodAD1.
// Reads both channels per frame and presents them as one AXI4-Stream beat.
//   aclk, aresetn            clock, active-low reset (async assert, sync release)
//   en                       level; high = back-to-back conversions (sampled in IDLE)
//   busy                     high from CS fall through end of QUIET
//   ad1_cs, ad1_sclk         SPI chip select (active low) and clock (idles high)
//   ad1_sdin0, ad1_sdin1     channel 0/1 serial data
//   m_axis_tdata/tvalid/tready  {4'h0, ch1[11:0], 4'h0, ch0[11:0]} output stream
//   overrun, overrun_clr     only with PMOD_AD1_OVERRUN_EN: sticky dropped-sample flag
module pmod_ad1_ctrl
    import pmod_ad1_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               en,
    output logic               busy,
    output logic               ad1_cs,
    output logic               ad1_sclk,
    input  logic               ad1_sdin0,
    input  logic               ad1_sdin1,
`ifdef PMOD_AD1_OVERRUN_EN
    output logic               overrun,
    input  logic               overrun_clr,
`endif
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    localparam int BW = cnt_w(FRAME_BITS);
    localparam int QW = cnt_w(QUIET_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYC - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [QW-1:0]        quiet_q, quiet_d;
    logic [DATA_BITS-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
    logic [TDATA_W-1:0]   tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 sclk_en, sclk_raw, rise_stb, fall_stb, frame_done;

    // Reset asserts immediately, releases two edges after aresetn rises.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign sclk_en = (state_q == START) || (state_q == SHIFT);

    pmod_ad1_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk_i      (aclk),
        .rst_ni     (rst_n),
        .en_i       (sclk_en),
        .sclk_o     (sclk_raw),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        quiet_d    = quiet_q;
        sr0_d      = sr0_q;
        sr1_d      = sr1_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                bit_d   = '0;
                quiet_d = '0;
                if (en) state_d = START;
            end
            START: if (fall_stb) state_d = SHIFT;
            SHIFT: begin
                // 16 bits shift through a 12-bit register: the leading
                // zeros fall off the top and only the sample remains.
                if (rise_stb) begin
                    bit_d = bit_q + 1'b1;
                    sr0_d = {sr0_q[DATA_BITS-2:0], ad1_sdin0};
                    sr1_d = {sr1_q[DATA_BITS-2:0], ad1_sdin1};
                end
                // The fall strobe after the 16th rise ends the last high phase.
                if (fall_stb && bit_q == BIT_LAST) begin
                    frame_done = 1'b1;
                    state_d    = QUIET;
                end
            end
            QUIET: begin
                if (quiet_q == QUIET_MAX) state_d = IDLE;
                else                      quiet_d = quiet_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A pending beat is never overwritten; a same-edge accept frees the slot.
        if (frame_done && (!tvalid_q || m_axis_tready)) begin
            tdata_d  = {{LEAD_ZEROS{1'b0}}, sr1_q, {LEAD_ZEROS{1'b0}}, sr0_q};
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            quiet_q  <= '0;
            sr0_q    <= '0;
            sr1_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            quiet_q  <= quiet_d;
            sr0_q    <= sr0_d;
            sr1_q    <= sr1_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef PMOD_AD1_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (frame_done && tvalid_q && !m_axis_tready) overrun_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    // The generator's phase toggles low on the closing edge; gating keeps
    // SCLK high as soon as CS rises.
    assign ad1_cs        = !sclk_en;
    assign ad1_sclk      = sclk_en ? sclk_raw : 1'b1;
    assign busy          = (state_q != IDLE);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_pmod_ad1_ctrl.sv
module tb_pmod_ad1_ctrl;

    logic        aclk = 1'b0, aresetn = 1'b0, en = 1'b0, tready = 1'b0;
    logic        sdin0 = 1'b0, sdin1 = 1'b0;
    logic        busy, cs, sclk, tvalid;
    logic [31:0] tdata;
`ifdef PMOD_AD1_OVERRUN_EN
    logic        overrun, overrun_clr = 1'b0;
`endif

    always #5 aclk = ~aclk;

    pmod_ad1_ctrl #(.CLK_DIV(2), .QUIET_CYC(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .en            (en),
        .busy          (busy),
        .ad1_cs        (cs),
        .ad1_sclk      (sclk),
        .ad1_sdin0     (sdin0),
        .ad1_sdin1     (sdin1),
`ifdef PMOD_AD1_OVERRUN_EN
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
`endif
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ADC model: a new word pair is latched at CS fall, bits go out MSB
    // first after each SCLK fall.
    logic [15:0] nxt0 = 16'h0, nxt1 = 16'h0, cur0 = 16'h0, cur1 = 16'h0;
    bit          rnd = 1'b0, frame_ok = 1'b0;
    int          rise_total = 0, rise_base = 0, fall_total = 0, fall_base = 0;

    always @(negedge cs or negedge aresetn) begin
        if (!aresetn) frame_ok = 1'b0;
        else begin
            cur0      = rnd ? 16'($urandom) : nxt0;
            cur1      = rnd ? 16'($urandom) : nxt1;
            rise_base = rise_total;
            fall_base = fall_total;
            frame_ok  = 1'b1;
        end
    end

    always @(negedge sclk) begin
        if (cs === 1'b0 && fall_total - fall_base < 16) begin
            sdin0 = cur0[15 - (fall_total - fall_base)];
            sdin1 = cur1[15 - (fall_total - fall_base)];
        end
        fall_total++;
    end

    always @(posedge sclk) if (cs === 1'b0) rise_total++;

    function automatic logic [31:0] beat_of(input logic [15:0] c0, input logic [15:0] c1);
        return {4'h0, c1[11:0], 4'h0, c0[11:0]};
    endfunction

    // Transaction-level reference: one output slot; a completed frame fills
    // it if it is empty or being emptied on that edge, otherwise it is lost.
    logic        p_cs = 1'b1, p_tv = 1'b0, p_tr = 1'b0, p_clr = 1'b0;
    logic [31:0] p_td = '0, pend = '0, last_rx = '0;
    bit          have = 1'b0, cont = 1'b0, have_fall = 1'b0, ovr_m = 1'b0;
    int          cyc = 0, done = 0, rx = 0, drop = 0, tv_cyc = 0, bad_int = 0;
    int          last_fall = 0, cs_low = 0, last_low = 0, last_rises = 0;

    always @(negedge aclk) begin
        bit hs, rose;
        cyc++;
        hs   = p_tv && p_tr;
        rose = !p_cs && cs && frame_ok && aresetn;
        if (!aresetn) begin
            have  = 1'b0;
            ovr_m = 1'b0;
        end else begin
            if (hs) begin
                chk("beat_data", p_td, pend);
                rx++;
                last_rx = p_td;
            end
            if (rose) begin
                done++;
                last_low   = cs_low;
                last_rises = rise_total - rise_base;
                if (p_clr) ovr_m = 1'b0;
                if (!have || hs) begin
                    have = 1'b1;
                    pend = beat_of(cur0, cur1);
                end else begin
                    drop++;
                    ovr_m = 1'b1;
                end
            end else begin
                if (hs) have = 1'b0;
                if (p_clr) ovr_m = 1'b0;
            end
            chk("tvalid", {31'h0, tvalid}, {31'h0, have});
            if (have) chk("tdata_hold", tdata, pend);
`ifdef PMOD_AD1_OVERRUN_EN
            chk("overrun_model", {31'h0, overrun}, {31'h0, ovr_m});
`endif
            if (tvalid) tv_cyc++;
        end
        if (p_cs && !cs) begin
            if (cont && have_fall && (cyc - last_fall) != 71) bad_int++;
            have_fall = cont;
            last_fall = cyc;
            cs_low    = 0;
        end
        if (!cs) cs_low++;
        p_cs = cs; p_tv = tvalid; p_tr = tready; p_td = tdata;
`ifdef PMOD_AD1_OVERRUN_EN
        p_clr = overrun_clr;
`endif
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done < target && k < budget) begin step(); k++; end
        chk("frame_wait", 32'(done >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin step(); k++; end
        chk("idle_wait", {31'h0, busy}, 32'h0);
    endtask

    task automatic one_frame(input logic [15:0] c0, input logic [15:0] c1);
        int d0 = done;
        nxt0 = c0; nxt1 = c1;
        en = 1'b1; step(); en = 1'b0;
        wait_done(d0 + 1, 200);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int rx0, tv0, d0, drop0, k;
        logic [15:0] a0, a1, b0, b1;

        // 1: reset state
        repeat (3) step();
        chk("rst_cs", {31'h0, cs}, 32'h1);
        chk("rst_sclk", {31'h0, sclk}, 32'h1);
        chk("rst_tvalid", {31'h0, tvalid}, 32'h0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        aresetn = 1'b1;
        repeat (4) step();

        // 2: single frame
        tready = 1'b1;
        rx0 = rx; tv0 = tv_cyc;
        one_frame(16'h0ABC, 16'h0123);
        repeat (2) step();
        chk("cs_low_cycles", 32'(last_low), 32'd66);
        chk("sclk_rises", 32'(last_rises), 32'd16);
        chk("single_beats", 32'(rx - rx0), 32'd1);
        chk("single_tdata", last_rx, 32'h01230ABC);
        chk("tvalid_width", 32'(tv_cyc - tv0), 32'd1);

        // 3: continuous conversion, random data
        rnd = 1'b1; cont = 1'b1;
        rx0 = rx; d0 = done; k = bad_int;
        en = 1'b1;
        wait_done(d0 + 10, 1200);
        en = 1'b0;
        wait_idle();
        repeat (2) step();
        cont = 1'b0;
        chk("cs_period", 32'(bad_int - k), 32'd0);
        chk("cont_beats", 32'(rx - rx0), 32'd10);

        // 4: backpressure across three frames
        rnd = 1'b0;
        a0 = 16'($urandom); a1 = 16'($urandom);
        nxt0 = a0; nxt1 = a1;
        tready = 1'b0; drop0 = drop; d0 = done;
        en = 1'b1; step(); rnd = 1'b1;
        wait_done(d0 + 3, 400);
        en = 1'b0;
        wait_idle();
        chk("bp_tvalid", {31'h0, tvalid}, 32'h1);
        chk("bp_tdata", tdata, beat_of(a0, a1));
        chk("bp_drops", 32'(drop - drop0), 32'd2);
`ifdef PMOD_AD1_OVERRUN_EN
        chk("overrun_set", {31'h0, overrun}, 32'h1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0; step();
        chk("overrun_clr", {31'h0, overrun}, 32'h0);
`endif
        rx0 = rx;
        tready = 1'b1; step(); step();
        chk("bp_beat", last_rx, beat_of(a0, a1));
        chk("bp_one_beat", 32'(rx - rx0), 32'd1);
        rnd = 1'b0;

        // 5: leading ones from the ADC are ignored
        one_frame(16'hFFFF, 16'hFFFF);
        step(); step();
        chk("lead_zeros", last_rx, 32'h0FFF0FFF);

        // 6: reset in the middle of SHIFT
        nxt0 = 16'($urandom); nxt1 = 16'($urandom);
        en = 1'b1; step(); en = 1'b0;
        k = 0;
        while ((rise_total - rise_base) != 7 && k < 200) begin step(); k++; end
        chk("rise7_wait", 32'(rise_total - rise_base), 32'd7);
        aresetn = 1'b0;
        #1;
        chk("midrst_cs", {31'h0, cs}, 32'h1);
        chk("midrst_sclk", {31'h0, sclk}, 32'h1);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        rx0 = rx;
        repeat (3) step();
        aresetn = 1'b1;
        repeat (4) step();
        chk("midrst_tvalid", {31'h0, tvalid}, 32'h0);
        b0 = 16'($urandom); b1 = 16'($urandom);
        one_frame(b0, b1);
        step(); step();
        chk("midrst_no_partial", 32'(rx - rx0), 32'd1);
        chk("after_rst_beat", last_rx, beat_of(b0, b1));

        // 7: random tready against the reference
        rnd = 1'b1; d0 = done;
        en = 1'b1;
        k = 0;
        while (done < d0 + 6 && k < 2000) begin
            tready = 1'($urandom_range(0, 1));
            step(); k++;
        end
        chk("rand_frames", 32'(done >= d0 + 6), 32'd1);
        en = 1'b0; tready = 1'b1;
        wait_idle();
        repeat (3) step();
        rnd = 1'b0;

        // 8: accept on the same edge a frame completes
        tready = 1'b0;
        a0 = 16'($urandom); a1 = 16'($urandom);
        one_frame(a0, a1);
        b0 = 16'($urandom); b1 = 16'($urandom);
        nxt0 = b0; nxt1 = b1;
        en = 1'b1; step(); en = 1'b0;
        k = 0;
        while (!(cs === 1'b0 && cs_low == 65) && k < 200) begin step(); k++; end
        chk("simul_wait", 32'(cs_low), 32'd65);
        rx0 = rx;
        tready = 1'b1; step(); tready = 1'b0;
        chk("simul_tvalid", {31'h0, tvalid}, 32'h1);
        chk("simul_tdata", tdata, beat_of(b0, b1));
        step();
        chk("simul_old_beat", last_rx, beat_of(a0, a1));
        tready = 1'b1; step(); step();
        chk("simul_new_beat", last_rx, beat_of(b0, b1));
        chk("simul_beats", 32'(rx - rx0), 32'd2);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
